// File: rtl/bus_select_pipe.sv
// bus_select_pipe: registered one-hot bus select with keeper, collision flag and optional counter (BUS_SELECT_COLLISION_COUNT_EN)
module bus_select_pipe #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 24,
   parameter int SEL_W    = 5
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [CHANNELS*WIDTH-1:0] in_flat,
   input  logic [CHANNELS-1:0]       drive_en,
   input  logic                      stall,
   output logic [WIDTH-1:0]          bus_out,
   output logic [SEL_W-1:0]          sel_out,
   output logic                      driven,
   output logic                      collision,
   output logic [7:0]                collision_count
);
   localparam logic [CHANNELS-1:0] ONE = 1;
   logic [SEL_W-1:0] win;
   logic [WIDTH-1:0] word;
   logic any, multi;
   always_comb begin
      win  = '0;
      word = in_flat[WIDTH-1:0];
      for (int i = 0; i < CHANNELS; i++)
         if (drive_en[i]) begin
            win  = i[SEL_W-1:0];
            word = in_flat[i*WIDTH +: WIDTH];
         end
   end
   assign any   = |drive_en;
   // clearing the lowest set bit leaves something only if two or more were set
   assign multi = |(drive_en & (drive_en - ONE));
   always_ff @(posedge clock)
      if (reset) begin
         bus_out   <= '0;
         sel_out   <= '0;
         driven    <= 1'b0;
         collision <= 1'b0;
      end else if (!stall) begin
         if (any) begin
            bus_out <= word;
            sel_out <= win;
         end
         driven    <= any;
         collision <= multi;
      end
`ifdef BUS_SELECT_COLLISION_COUNT_EN
   always_ff @(posedge clock)
      if (reset) collision_count <= 8'h00;
      else if (!stall && multi && collision_count != 8'hFF) collision_count <= collision_count + 8'h01;
`else
   assign collision_count = 8'h00;
`endif
endmodule

// File: tb/tb_bus_select_pipe.sv
// tb_bus_select_pipe: randomized scoreboard bench for bus_select_pipe against a queue-based reference model
module tb_bus_select_pipe;
   localparam int W = 32;
   localparam int C = 24;
   localparam int S = 5;
   typedef struct {
      logic [W-1:0] bus;
      logic [S-1:0] sel;
      logic         drv;
      logic         col;
      logic [7:0]   cnt;
   } exp_t;
   logic clock = 1'b0, reset = 1'b1, stall = 1'b0;
   logic [C*W-1:0] in_flat;
   logic [C-1:0] drive_en = '0;
   logic [W-1:0] bus_out;
   logic [S-1:0] sel_out;
   logic driven, collision;
   logic [7:0] collision_count;
   logic [W-1:0] words [C];
   logic [W-1:0] nw [C];
   exp_t q[$];
   int vectors = 0, miscompares = 0;
   logic [W-1:0] m_bus = '0;
   logic [S-1:0] m_sel = '0;
   logic m_drv = 1'b0, m_col = 1'b0;
   int m_cnt = 0;

   bus_select_pipe #(.WIDTH(W), .CHANNELS(C), .SEL_W(S)) dut (
      .clock(clock), .reset(reset), .in_flat(in_flat), .drive_en(drive_en), .stall(stall),
      .bus_out(bus_out), .sel_out(sel_out), .driven(driven), .collision(collision),
      .collision_count(collision_count)
   );

   always #5 clock = ~clock;
   for (genvar g = 0; g < C; g++) assign in_flat[g*W +: W] = words[g];

   task automatic step(input logic [C-1:0] en, input logic st, input logic rs);
      exp_t e;
      int n;
      @(negedge clock);
      for (int k = 0; k < C; k++) words[k] = nw[k];
      drive_en = en;
      stall = st;
      reset = rs;
      n = $countones(en);
      if (rs) begin
         m_bus = '0; m_sel = '0; m_drv = 1'b0; m_col = 1'b0; m_cnt = 0;
      end else if (!st) begin
         for (int k = C - 1; k >= 0; k--)
            if (en[k]) begin
               m_bus = words[k];
               m_sel = S'(k);
               break;
            end
         m_drv = n > 0;
         m_col = n > 1;
         if (n > 1 && m_cnt < 255) m_cnt++;
      end
      e.bus = m_bus; e.sel = m_sel; e.drv = m_drv; e.col = m_col;
`ifdef BUS_SELECT_COLLISION_COUNT_EN
      e.cnt = 8'(m_cnt);
`else
      e.cnt = 8'h00;
`endif
      q.push_back(e);
      @(posedge clock);
   endtask

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at vector %0d", name, act, exp, vectors);
      end
   endtask

   always @(posedge clock) begin
      #1;
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         vectors++;
         chk("bus_out", bus_out, e.bus);
         chk("sel_out", W'(sel_out), W'(e.sel));
         chk("driven", W'(driven), W'(e.drv));
         chk("collision", W'(collision), W'(e.col));
         chk("collision_count", W'(collision_count), W'(e.cnt));
      end
   end

   function automatic logic [C-1:0] bit1(input int k);
      logic [C-1:0] v;
      v = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      for (int k = 0; k < C; k++) begin nw[k] = '0; words[k] = '0; end
      nw[0] = 32'hDEAD_BEEF;
      step(bit1(0), 1'b0, 1'b1);
      step(bit1(0), 1'b0, 1'b1);
      step(bit1(0), 1'b0, 1'b0);
      nw[21] = 32'h0000_0001;
      step(bit1(21), 1'b0, 1'b0);
      repeat (3) step('0, 1'b0, 1'b0);
      nw[3] = 32'h3;
      nw[17] = 32'h17;
      step(bit1(3) | bit1(17), 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) step(bit1(3) | bit1(17) | ($urandom & 24'hFFFFFF), 1'b0, 1'b0);
      step(bit1(3) | bit1(17), 1'b0, 1'b0);
      step('0, 1'b0, 1'b1);
      step(bit1(1) | bit1(2), 1'b0, 1'b0);
      nw[5] = 32'hA5A5_A5A5;
      step(bit1(5), 1'b0, 1'b0);
      nw[6] = 32'h6;
      nw[7] = 32'h7;
      repeat (3) step(bit1(6) | bit1(7), 1'b1, 1'b0);
      step(bit1(6) | bit1(7), 1'b0, 1'b0);
      step(bit1(6), 1'b1, 1'b1);
      step('0, 1'b0, 1'b0);
      for (int i = 0; i < 250; i++) begin
         logic [C-1:0] en;
         int r;
         for (int k = 0; k < C; k++) nw[k] = $urandom;
         r = $urandom_range(0, 3);
         en = r == 0 ? '0 : r == 1 ? bit1($urandom_range(0, C - 1)) :
              r == 2 ? bit1($urandom_range(0, C - 1)) | bit1($urandom_range(0, C - 1)) :
              C'($urandom);
         step(en, $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0);
      end
      #5;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected entries left, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
